// File: rtl/mp_out_packer.sv
// Packs the pooled byte stream into LANES-byte words and queues them in a FWFT FIFO.
// Optional word_cnt output (successful pops) is enabled by defining MP_PACK_WORD_CNT_EN.
module mp_out_packer #(
    parameter int unsigned LANES = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [7:0]           in,
    input  logic                 in_en,
    input  logic                 flush,
    output logic [8*LANES-1:0]   out_data,
    output logic [LANES-1:0]     out_mask,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 overflow,
    output logic                 busy
`ifdef MP_PACK_WORD_CNT_EN
    ,
    output logic [15:0]          word_cnt
`endif
);

    localparam int unsigned CW    = $clog2(LANES);
    localparam int unsigned AW    = $clog2(DEPTH);
    localparam int unsigned OCC_W = AW + 1;

    logic [CW-1:0]        count;
    logic [8*LANES-1:0]   asm_data;
    logic [8*LANES-1:0]   word_data;
    logic [LANES-1:0]     push_mask;
    logic [CW:0]          filled;
    logic                 full_word;
    logic                 push;
    logic                 push_ok;
    logic                 pop;
    logic                 fifo_full;

    logic [8*LANES-1:0]   mem_data [DEPTH];
    logic [LANES-1:0]     mem_mask [DEPTH];
    logic [AW-1:0]        wr_ptr;
    logic [AW-1:0]        rd_ptr;
    logic [OCC_W-1:0]     occ;

    // The incoming byte is merged before deciding on a push, so flush+in_en
    // yields one word that already includes this byte.
    always_comb begin
        word_data = asm_data;
        for (int unsigned i = 0; i < LANES; i++) begin
            if (in_en && count == CW'(i))
                word_data[i*8 +: 8] = in;
        end
        filled = {1'b0, count} + (CW+1)'(in_en);
        push_mask = '0;
        for (int unsigned i = 0; i < LANES; i++) begin
            push_mask[i] = (i < 32'(filled));
        end
    end

    assign full_word = in_en && (count == CW'(LANES - 1));
    assign push      = full_word || (flush && filled != '0);
    assign fifo_full = (occ == OCC_W'(DEPTH));
    assign out_valid = (occ != '0);
    assign pop       = out_valid && out_ready;
    assign push_ok   = push && (!fifo_full || pop);
    assign busy      = (count != '0) || (occ != '0);
    assign out_data  = out_valid ? mem_data[rd_ptr] : '0;
    assign out_mask  = out_valid ? mem_mask[rd_ptr] : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            count    <= '0;
            asm_data <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            occ      <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) begin
                count    <= '0;
                asm_data <= '0;
            end else if (in_en) begin
                count    <= count + CW'(1);
                asm_data <= word_data;
            end
            if (push_ok)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            if (push_ok && !pop)
                occ <= occ + OCC_W'(1);
            else if (pop && !push_ok)
                occ <= occ - OCC_W'(1);
            if (push && fifo_full && !pop)
                overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_data[wr_ptr] <= word_data;
            mem_mask[wr_ptr] <= push_mask;
        end
    end

`ifdef MP_PACK_WORD_CNT_EN
    always_ff @(posedge clk) begin
        if (reset)
            word_cnt <= '0;
        else if (pop)
            word_cnt <= word_cnt + 16'd1;
    end
`endif

endmodule

// File: tb/tb_mp_out_packer.sv
// Directed self-checking bench for mp_out_packer at LANES=8, DEPTH=4.
module tb_mp_out_packer;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  in;
    logic        in_en;
    logic        flush;
    logic [63:0] out_data;
    logic [7:0]  out_mask;
    logic        out_valid;
    logic        out_ready;
    logic        overflow;
    logic        busy;
`ifdef MP_PACK_WORD_CNT_EN
    logic [15:0] word_cnt;
`endif

    int n_cmp = 0;
    int n_err = 0;

    mp_out_packer #(.LANES(8), .DEPTH(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .in        (in),
        .in_en     (in_en),
        .flush     (flush),
        .out_data  (out_data),
        .out_mask  (out_mask),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .overflow  (overflow),
        .busy      (busy)
`ifdef MP_PACK_WORD_CNT_EN
        ,
        .word_cnt  (word_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Word whose n low bytes count up from base; upper bytes zero.
    function automatic logic [63:0] mkword(input logic [7:0] base, input int n);
        logic [63:0] w = '0;
        for (int j = 0; j < n; j++) w[j*8 +: 8] = base + 8'(j);
        return w;
    endfunction

    task automatic send(input logic [7:0] b);
        in = b;
        in_en = 1'b1;
        tick();
        in_en = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; in = '0; in_en = 1'b0; flush = 1'b0; out_ready = 1'b0;
        tick(); tick();
        reset = 1'b0;
        check("rst_valid", out_valid, 0);
        check("rst_data", out_data, 0);
        check("rst_mask", out_mask, 0);
        check("rst_ovf", overflow, 0);
        check("rst_busy", busy, 0);

        // Two full words streamed back to back with the consumer ready.
        out_ready = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            in = 8'(i);
            in_en = 1'b1;
            tick();
            if (i == 7)  check("s_valid_b7", out_valid, 0);
            if (i == 8) begin
                check("s_valid_b8", out_valid, 1);
                check("s_word0", out_data, 64'h0807060504030201);
                check("s_mask0", out_mask, 8'hFF);
            end
            if (i == 9)  check("s_valid_b9", out_valid, 0);
            if (i == 16) begin
                check("s_valid_b16", out_valid, 1);
                check("s_word1", out_data, 64'h100F0E0D0C0B0A09);
                check("s_mask1", out_mask, 8'hFF);
            end
        end
        in_en = 1'b0;
        tick();
        check("s_drained", out_valid, 0);
        check("s_ovf", overflow, 0);
        check("s_busy", busy, 0);

        // Partial word via lone flush.
        out_ready = 1'b0;
        send(8'hAA); send(8'hBB); send(8'hCC);
        check("p_busy_pre", busy, 1);
        check("p_valid_pre", out_valid, 0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("p_valid", out_valid, 1);
        check("p_word", out_data, 64'h0000000000CCBBAA);
        check("p_mask", out_mask, 8'h07);
        tick();
        check("p_hold", out_data, 64'h0000000000CCBBAA);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("p_valid_post", out_valid, 0);
        check("p_busy_post", busy, 0);

        // Flush together with the 5th byte, then an empty flush.
        for (int i = 0; i < 4; i++) send(8'h11 + 8'(i));
        in = 8'h15; in_en = 1'b1; flush = 1'b1;
        tick();
        in_en = 1'b0;
        check("f5_word", out_data, 64'h0000001514131211);
        check("f5_mask", out_mask, 8'h1F);
        tick();
        flush = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("f5_single", out_valid, 0);
        check("f5_busy", busy, 0);

        // Overflow: 5 words into a 4-deep FIFO with no consumer.
        for (int k = 0; k < 40; k++) begin
            send(8'(k));
            if (k == 31) check("o_ovf_full", overflow, 0);
        end
        check("o_ovf_set", overflow, 1);
        tick();
        check("o_ovf_sticky", overflow, 1);
        out_ready = 1'b1;
        for (int w = 0; w < 4; w++) begin
            check($sformatf("o_valid%0d", w), out_valid, 1);
            check($sformatf("o_word%0d", w), out_data, mkword(8'(8*w), 8));
            tick();
        end
        check("o_empty", out_valid, 0);
        check("o_ovf_after", overflow, 1);
        out_ready = 1'b0;
        do_reset();
        check("o_ovf_cleared", overflow, 0);

        // Full FIFO, simultaneous pop and push on the 8th byte of word 4.
        for (int k = 0; k < 39; k++) send(8'h40 + 8'(k));
        in = 8'h40 + 8'd39; in_en = 1'b1; out_ready = 1'b1;
        tick();
        in_en = 1'b0; out_ready = 1'b0;
        check("sp_ovf", overflow, 0);
        check("sp_head", out_data, mkword(8'h48, 8));
        out_ready = 1'b1;
        for (int w = 1; w < 5; w++) begin
            check($sformatf("sp_valid%0d", w), out_valid, 1);
            check($sformatf("sp_word%0d", w), out_data, mkword(8'h40 + 8'(8*w), 8));
            tick();
        end
        check("sp_empty", out_valid, 0);
        out_ready = 1'b0;

        // Reset with 2 queued words and a 3-byte partial word.
        for (int k = 0; k < 19; k++) send(8'h60 + 8'(k));
        check("r_busy_pre", busy, 1);
        do_reset();
        check("r_valid", out_valid, 0);
        check("r_busy", busy, 0);
        check("r_data", out_data, 0);
        for (int k = 0; k < 8; k++) send(8'h81 + 8'(k));
        check("r_valid_new", out_valid, 1);
        check("r_word_new", out_data, 64'h8887868584838281);
        check("r_mask_new", out_mask, 8'hFF);
        out_ready = 1'b1;
        tick();
        check("r_drained", out_valid, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mp_out_packer.md
Name: mp_out_packer

Overview:
- Downstream neighbour of the maxpooling stage.
- Consumes the 8-bit pooled byte stream (maxpooling out/out_en) and packs LANES bytes into one wide word.
- Buffers packed words in a small FIFO and presents them to the feature-map write port over a valid/ready handshake.
- Supports flushing a partial word with a byte mask at the end of a row or map.

Parameters:
- LANES, 8, bytes per packed output word (power of two, 2..16).
- DEPTH, 4, FIFO depth in words (power of two, 2..16).

Ports:
- clk  input  1  system clock, all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- in  input  8  pooled byte from maxpooling out.
- in_en  input  1  byte valid, driven from maxpooling out_en.
- flush  input  1  single-cycle pulse that pushes the pending partial word.
- out_data  output  8*LANES  packed word; byte 0 occupies bits [7:0].
- out_mask  output  LANES  valid-byte mask for out_data; bit i qualifies byte i.
- out_valid  output  1  FIFO head valid.
- out_ready  input  1  consumer accepts the head word when out_valid && out_ready.
- overflow  output  1  sticky flag: a word was dropped because the FIFO was full.
- busy  output  1  high when the assembly count is nonzero or the FIFO is not empty.

Behaviour:
- Reset (synchronous, active-high): assembly register=0, count=0, FIFO empty. out_valid=0, out_data=0, out_mask=0, overflow=0, busy=0. Reset mid-operation discards the partial word and all FIFO contents.
- Assembly: at each edge with in_en=1, byte in is written to lane count, then count increments. No backpressure to upstream; every in_en byte is sampled.
- Full word:
  - When the byte lands in lane LANES-1, the word {assembled bytes} with mask all ones is pushed at that same edge, and count returns to 0.
  - The word is visible at the FIFO head (out_valid=1) in the cycle after that edge if the FIFO was empty: latency 1 cycle from the last byte.
- Flush:
  - flush=1 with count>0: the partial word is pushed at that edge. Unwritten lanes are 0 and out_mask has bits [count-1:0] set. count resets to 0.
  - flush=1 together with in_en=1: the byte is included first. If this completes the word, a single full word is pushed; otherwise a partial word with count+1 bytes is pushed.
  - flush=1 with count=0 and in_en=0: no-op.
- FIFO:
  - First-word-fall-through. out_data/out_mask are driven from the head entry.
  - Pop occurs at an edge with out_valid && out_ready.
  - Push and pop in the same cycle are allowed at any occupancy, including full; occupancy is unchanged.
  - Push when full and no pop: the word is dropped, overflow is set and stays 1 until reset, and FIFO contents are unchanged.
  - out_data and out_mask are held stable while out_valid=1 && out_ready=0.
- Pointers wrap modulo DEPTH. Occupancy counter width is clog2(DEPTH)+1, so full (occupancy=DEPTH) and empty (0) are distinguished.
- out_ready while out_valid=0: ignored.
- busy is combinational from count and occupancy.

Optional Feature:
- Macro: MP_PACK_WORD_CNT_EN.
- Defined: adds output word_cnt[15:0], reset to 0, incremented on every successful pop (full or partial word), wraps 16'hFFFF -> 0.
- Undefined: port and counter are absent; all other behaviour is identical.

Test Plan:
- Stream 16 bytes 0x01..0x10 at in_en=1 on consecutive cycles with out_ready=1 -> two words 0x0807060504030201 and 0x100F0E0D0C0B0A09, each with out_mask=0xFF. out_valid rises one cycle after bytes 8 and 16. overflow=0.
- Send 3 bytes 0xAA,0xBB,0xCC, then pulse flush alone -> one word 0x0000000000CCBBAA, out_mask=0x07. busy falls to 0 after the pop.
- Send 5 bytes with flush asserted together with the 5th byte -> a single word with out_mask=0x1F. A further flush with count=0 produces no push.
- Hold out_ready=0 and stream 40 bytes (5 words) at DEPTH=4 -> FIFO holds the first 4 words, the 5th is dropped, overflow=1 and stays set. Releasing out_ready then drains exactly the 4 retained words in order.
- FIFO full with out_ready=1 on the same edge that the 8th byte arrives -> simultaneous pop and push, nothing dropped, overflow stays 0, occupancy stays 4.
- Assert reset for one cycle after 3 bytes and 2 queued words -> out_valid=0, busy=0. The next 8 bytes form a clean word with out_mask=0xFF.
